ahb_slv_mem_responder: RTL and testbench
========================================

# ahb_slv_mem_responder

Parametrised AHB slave bench model that supersedes the incrementing-counter responder: a byte-addressable backing memory, programmable wait states, the two-cycle ERROR response, byte-lane writes by `hsize`, and a single-master grant model. It sits on the slave side of the bus under test in `tb/`. It gives scoreboards deterministic, checkable read data and exercises master-side `hready`/`hresp` handling.

## Interface
Parameters:
- `DATA_W`, 64, data bus width (32 or 64).
- `ADDR_W`, 32, address width.
- `MEM_DEPTH`, 1024, backing memory depth in `DATA_W` words (power of two).
- `WAIT_CYCLES`, 0, wait states inserted per data phase (max 15).
- `MASTER_ID`, 1, value driven on `hmaster` once granted.
- `LFSR_SEED`, 16'hACE1, random-wait seed (only with macro).

Ports (one clock; reset is synchronous and active-high):
- `hclk` in 1: clock.
- `hreset` in 1: synchronous active-high reset.
- `hsel` in 1: slave select.
- `haddr` in `ADDR_W`: address.
- `htrans` in 2: IDLE/BUSY/NONSEQ/SEQ.
- `hwrite` in 1: 1 = write.
- `hsize` in 3: transfer size.
- `hburst` in 3: burst type (informational; addressing follows `haddr`).
- `hwdata` in `DATA_W`: write data.
- `hbusreq` in 1: bus request.
- `hlock` in 1: ignored.
- `hrdata` out `DATA_W`: read data.
- `hready` out 1: transfer done.
- `hresp` out 2: OKAY = 0, ERROR = 1.
- `hgrant` out 1: grant.
- `hmaster` out 4: current master.

## Operation
- Address phase accepted when `hsel && hready && htrans ∈ {NONSEQ,SEQ}`. The block captures addr, write, size, and the error flag. IDLE/BUSY get a zero-wait OKAY.
- Error flag set when any of:
  - word index `haddr / (DATA_W/8) >= MEM_DEPTH`;
  - `2**hsize > DATA_W/8`;
  - `haddr` is not aligned to `2**hsize`.
- FSM states:
  - IDLE: `hready`=1, OKAY.
  - WAIT: `hready`=0, OKAY; a down-counter runs from the per-transfer wait count.
  - DATA: `hready`=1, OKAY; transfer completes.
  - ERR1: `hready`=0, ERROR.
  - ERR2: `hready`=1, ERROR.
- Transitions on accept:
  - error flag set → ERR1 → ERR2;
  - else wait count > 0 → WAIT, then DATA when the counter reaches 1;
  - else → DATA.
  - From DATA or ERR2: a new accepted transfer restarts the sequence; otherwise go to IDLE.
- Writes: memory updated at the clock edge ending the DATA cycle. Only byte lanes `[addr%bytes +: 2**size]` are written from `hwdata`. Errored writes never modify memory.
- Reads: `hrdata` = full word at the captured index, combinational in WAIT/DATA; 0 in IDLE/ERR states.
- Write data phase followed by a read of the same address returns the new data, with no hazard.
- Back-to-back transfers: an address phase overlaps the previous DATA/ERR2 cycle (pipelined AHB).
- Grant model: `hgrant` <= `hbusreq`, registered. `hmaster` <= `MASTER_ID` when `hgrant && hready`; otherwise it holds.

## Timing
- Reset (sync, `hreset`=1 at a `hclk` edge) forces:
  - outputs: `hready`=1, `hresp`=0, `hrdata`=0, `hgrant`=0, `hmaster`=0;
  - internal: state IDLE, counter 0;
  - memory cleared to 0 (bench model).
- Reset mid-transfer abandons the transfer; no memory write occurs in that cycle.
- Zero-wait read: `hrdata` valid in the cycle after the address phase.
- N waits: `hready` low for N cycles, then high with data.
- ERROR: exactly two cycles, `hready` 0 then 1, `hresp`=1 in both.
- Wait counter is 4 bits and saturates; `WAIT_CYCLES` > 15 is a compile-time error.

## Configuration
- `AHB_RSP_RAND_WAIT_EN` defined:
  - a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed `LFSR_SEED`, reset to seed) advances on each accept;
  - wait count = `lfsr[3:0] % (WAIT_CYCLES+1)`.
- `AHB_RSP_RAND_WAIT_EN` undefined: every transfer uses exactly `WAIT_CYCLES`, and no LFSR is present.

## Structure
- Package `ahb_rsp_pkg`:
  - `htrans_e`, `hresp_e`, `rsp_state_e`;
  - size/alignment helper function;
  - `ERROR`/`OKAY` constants.
- Sub-module `ahb_rsp_lfsr`, instantiated only under the macro.

## Test plan
- Reset then idle: `htrans`=IDLE for 5 cycles → `hready`=1, `hresp`=0, `hrdata`=0, memory untouched.
- `WAIT_CYCLES`=0, write 64'h1122334455667788 to 0x10, then read 0x10 → `hrdata`=64'h1122334455667788 one cycle after the read address phase.
- Byte write `hsize`=0 of 8'hAA at 0x13 over a word of zeros, then word read of 0x10 → 64'h00000000AA000000.
- `WAIT_CYCLES`=3, INCR4 read at 0x0 → each beat has 3 cycles of `hready`=0, then data. Total 16 cycles, data 0,0,0,0 after reset.
- Read at `MEM_DEPTH*8` (out of range), and `hsize`=2 at 0x2 (misaligned) → `hresp`=1 for two cycles with `hready` 0 then 1. The following OKAY read completes normally.
- Assert `hreset` during the WAIT phase of a write → next cycle in IDLE with `hready`=1, and the target word still reads 0.

Source files
------------

// File: rtl/ahb_rsp_pkg.sv
// Shared types, response constants and the size/alignment helper for the
// AHB slave memory responder.
package ahb_rsp_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'd0,
    HRESP_ERROR = 2'd1
  } hresp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } rsp_state_e;

  localparam logic [1:0] OKAY  = 2'd0;
  localparam logic [1:0] ERROR = 2'd1;
  localparam int unsigned MAX_WAIT = 15;

  // True when the transfer is wider than the bus or its address is not
  // a multiple of the transfer size.
  function automatic logic size_align_err(input logic [2:0] hsize,
                                          input logic [6:0] addr_lo,
                                          input int unsigned bus_bytes);
    int unsigned nbytes;
    nbytes = 32'd1 << hsize;
    return (nbytes > bus_bytes) || ((32'(addr_lo) & (nbytes - 32'd1)) != 32'd0);
  endfunction

endpackage

// File: rtl/ahb_rsp_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) that steps once per accepted
// transfer; used for random wait states when AHB_RSP_RAND_WAIT_EN is defined.
module ahb_rsp_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adv,
  output logic [15:0] lfsr
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (adv) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/ahb_slv_mem_responder.sv
// AHB slave bench model: byte-addressable memory, programmable wait states,
// two-cycle ERROR response and a registered grant. Macro AHB_RSP_RAND_WAIT_EN.
module ahb_slv_mem_responder
  import ahb_rsp_pkg::*;
#(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned MEM_DEPTH   = 1024,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned MASTER_ID   = 1,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic [DATA_W-1:0] hwdata,
  input  logic              hbusreq,
  input  logic              hlock,
  output logic [DATA_W-1:0] hrdata,
  output logic              hready,
  output logic [1:0]        hresp,
  output logic              hgrant,
  output logic [3:0]        hmaster
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);
  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W + 1)'(MEM_DEPTH * BYTES);

  if (WAIT_CYCLES > MAX_WAIT) begin : g_wait_range
    $error("WAIT_CYCLES must not exceed 15");
  end

  rsp_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [2:0]        size_q, size_d;
  logic              write_q, write_d;
  logic              hgrant_q, hgrant_d;
  logic [3:0]        hmaster_q, hmaster_d;
  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  logic              accept;
  logic              addr_err;
  logic [3:0]        xfer_wait;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic              unused_inputs;

  assign unused_inputs = ^{hburst, hlock};

`ifdef AHB_RSP_RAND_WAIT_EN
  logic [15:0] lfsr;

  ahb_rsp_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk  (hclk),
    .rst  (hreset),
    .adv  (accept),
    .lfsr (lfsr)
  );

  assign xfer_wait = 4'(lfsr[3:0] % 5'(WAIT_CYCLES + 1));
`else
  localparam logic [15:0] unused_seed = LFSR_SEED;

  assign xfer_wait = 4'(WAIT_CYCLES);
`endif

  assign accept   = hsel && hready && ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
  assign addr_err = ({1'b0, haddr} >= MEM_BYTES) || size_align_err(hsize, haddr[6:0], BYTES);

  always_comb begin
    hready = 1'b1;
    hresp  = OKAY;
    hrdata = '0;
    unique case (state_q)
      ST_WAIT: begin
        hready = 1'b0;
        hrdata = mem_q[idx_q];
      end
      ST_DATA: hrdata = mem_q[idx_q];
      ST_ERR1: begin
        hready = 1'b0;
        hresp  = ERROR;
      end
      ST_ERR2: hresp = ERROR;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    off_d   = off_q;
    size_d  = size_q;
    write_d = write_q;
    unique case (state_q)
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = ST_DATA;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        // IDLE, DATA and ERR2 drive hready high, so a new address phase may land here.
        state_d = ST_IDLE;
        if (accept) begin
          idx_d   = haddr[OFF_W +: IDX_W];
          off_d   = haddr[OFF_W-1:0];
          size_d  = hsize;
          write_d = hwrite;
          if (addr_err) begin
            state_d = ST_ERR1;
          end else if (xfer_wait != 4'd0) begin
            state_d = ST_WAIT;
            cnt_d   = xfer_wait;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
    endcase
  end

  // Merge only the addressed byte lanes into the stored word.
  always_comb begin
    mem_we    = (state_q == ST_DATA) && write_q;
    mem_wdata = mem_q[idx_q];
    for (int b = 0; b < int'(BYTES); b++) begin
      if ((b >= int'(off_q)) && (b < int'(off_q) + (1 << size_q))) begin
        mem_wdata[8*b +: 8] = hwdata[8*b +: 8];
      end
    end
  end

  assign hgrant_d  = hbusreq;
  assign hmaster_d = (hgrant_q && hready) ? 4'(MASTER_ID) : hmaster_q;

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      idx_q     <= '0;
      off_q     <= '0;
      size_q    <= 3'd0;
      write_q   <= 1'b0;
      hgrant_q  <= 1'b0;
      hmaster_q <= 4'd0;
      for (int i = 0; i < int'(MEM_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      off_q     <= off_d;
      size_q    <= size_d;
      write_q   <= write_d;
      hgrant_q  <= hgrant_d;
      hmaster_q <= hmaster_d;
      if (mem_we) begin
        mem_q[idx_q] <= mem_wdata;
      end
    end
  end

  assign hgrant  = hgrant_q;
  assign hmaster = hmaster_q;

endmodule

// File: tb/tb_ahb_slv_mem_responder.sv
// Bench for ahb_slv_mem_responder: a zero-wait and a three-wait instance
// checked by a bus monitor against a byte-array reference memory.
module tb_ahb_slv_mem_responder;

  localparam int MD = 1024;
  localparam int W  = 70;  // {err, write, waits[3:0], rdata[63:0]}

  logic        hclk;
  logic        hreset;
  logic        hsel    [2];
  logic [31:0] haddr   [2];
  logic [1:0]  htrans  [2];
  logic        hwrite  [2];
  logic [2:0]  hsize   [2];
  logic [2:0]  hburst  [2];
  logic [63:0] hwdata  [2];
  logic        hbusreq [2];
  logic        hlock   [2];
  logic [63:0] hrdata  [2];
  logic        hready  [2];
  logic [1:0]  hresp   [2];
  logic        hgrant  [2];
  logic [3:0]  hmaster [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ahb_slv_mem_responder #(
      .DATA_W      (64),
      .ADDR_W      (32),
      .MEM_DEPTH   (MD),
      .WAIT_CYCLES (g == 0 ? 0 : 3),
      .MASTER_ID   (g == 0 ? 5 : 9),
      .LFSR_SEED   (16'hACE1)
    ) u_dut (
      .hclk    (hclk),
      .hreset  (hreset),
      .hsel    (hsel[g]),
      .haddr   (haddr[g]),
      .htrans  (htrans[g]),
      .hwrite  (hwrite[g]),
      .hsize   (hsize[g]),
      .hburst  (hburst[g]),
      .hwdata  (hwdata[g]),
      .hbusreq (hbusreq[g]),
      .hlock   (hlock[g]),
      .hrdata  (hrdata[g]),
      .hready  (hready[g]),
      .hresp   (hresp[g]),
      .hgrant  (hgrant[g]),
      .hmaster (hmaster[g])
    );
  end

  // ---------------- clock ----------------
  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  int cyc;
  initial begin
    cyc = 0;
    forever begin
      @(posedge hclk);
      cyc++;
    end
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [7:0]   ref_mem [2][MD*8];
  int           n_cmp;
  int           n_bad;
  int           acc_cyc;
  int           last_done;
  logic [63:0]  last_rdata;

  task automatic check(input string name, input int d, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %h, required %h (t=%0t)", name, d, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic model_err(input logic [31:0] a, input logic [2:0] sz);
    int unsigned nb;
    nb = 32'd1 << sz;
    return ((a / 8) >= MD) || (nb > 8) || ((a % nb) != 0);
  endfunction

  function automatic logic [63:0] model_read(input int d, input logic [31:0] a);
    logic [63:0] r;
    int base;
    base = int'(a / 8) * 8;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = ref_mem[d][base + k];
    return r;
  endfunction

  task automatic model_write(input int d, input logic [31:0] a, input logic [2:0] sz,
                             input logic [63:0] wd);
    int nb;
    int lane;
    nb   = 1 << sz;
    lane = int'(a % 8);
    for (int k = 0; k < nb; k++) ref_mem[d][int'(a) + k] = wd[8*(lane + k) +: 8];
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < MD*8; i++) ref_mem[d][i] = 8'h00;
  endtask

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    hreset = 1'b1;
    @(posedge hclk); #1;
    @(posedge hclk); #1;
    hreset = 1'b0;
    clear_model();
    exp_q.delete();
  endtask

  task automatic wait_ready(input int d);
    int guard;
    guard = 0;
    @(negedge hclk);
    while (!hready[d] && guard < 64) begin
      @(negedge hclk);
      guard++;
    end
    if (!hready[d]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout dut%0d: hready 0 for %0d cycles, required 1", d, guard);
    end
  endtask

  task automatic issue(input int d, input logic [31:0] a, input logic wr, input logic [2:0] sz,
                       input logic [63:0] wd, input logic [1:0] tr, input logic [2:0] bu);
    logic        err;
    logic [63:0] rd;
    logic [3:0]  wt;
    err = model_err(a, sz);
    rd  = '0;
    if (!err) begin
      if (wr) model_write(d, a, sz, wd);
      else rd = model_read(d, a);
    end
    wt = err ? 4'd1 : 4'(wait_of(d));
    exp_q.push_back({err, wr, wt, rd});
    hsel[d]   = 1'b1;
    haddr[d]  = a;
    hwrite[d] = wr;
    hsize[d]  = sz;
    htrans[d] = tr;
    hburst[d] = bu;
    wait_ready(d);
    @(posedge hclk); #1;
    acc_cyc   = cyc;
    hwdata[d] = wd;
    htrans[d] = 2'd0;
  endtask

  task automatic idle(input int d, input int n);
    repeat (n) begin
      htrans[d] = 2'($urandom_range(0, 1));  // IDLE or BUSY, never accepted
      @(posedge hclk); #1;
    end
    htrans[d] = 2'd0;
  endtask

  task automatic drain(input int d);
    int guard;
    guard = 0;
    htrans[d] = 2'd0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(posedge hclk); #1;
      guard++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout dut%0d: %0d responses outstanding, required 0", d, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic rand_xfer(input int d);
    int          kind;
    logic [2:0]  sz;
    logic [31:0] a;
    int unsigned nb;
    kind = $urandom_range(0, 9);
    sz   = 3'($urandom_range(0, 3));
    nb   = 32'd1 << sz;
    if (kind == 0) begin
      a = 32'(MD*8) + 32'($urandom_range(0, 31) * 8);
    end else if (kind == 1) begin
      sz = 3'($urandom_range(1, 3));
      nb = 32'd1 << sz;
      a  = (32'($urandom_range(0, 255)) & ~(nb - 1)) + 32'd1;
    end else if (kind == 2) begin
      a = (32'(MD*8 - 16) + 32'($urandom_range(0, 15))) & ~(nb - 1);
    end else begin
      a = 32'($urandom_range(0, 255)) & ~(nb - 1);
    end
    issue(d, a, 1'($urandom_range(0, 1)), sz, {$urandom, $urandom},
          2'($urandom_range(2, 3)), 3'd1);
    if ($urandom_range(0, 3) == 0) idle(d, $urandom_range(1, 2));
  endtask

  // ---------------- monitor ----------------
  logic pend    [2];
  int   low_cnt [2];
  logic low_err [2];

  task automatic complete(input int d);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_rsp dut%0d: response with hresp %0d, required none", d, hresp[d]);
    end else begin
      e = exp_q.pop_front();
      if (e[69]) begin
        check("err_resp", d, 64'(hresp[d]), 64'd1);
        check("err_low_cycles", d, 64'(low_cnt[d]), 64'd1);
        check("err_first_resp", d, 64'(low_err[d]), 64'd1);
        check("err_rdata", d, hrdata[d], 64'd0);
      end else begin
        check("okay_resp", d, 64'(hresp[d]), 64'd0);
        check("wait_cycles", d, 64'(low_cnt[d]), 64'(e[67:64]));
        check("wait_resp", d, 64'(low_err[d]), 64'd0);
        if (!e[68]) check("rdata", d, hrdata[d], e[63:0]);
      end
      last_rdata = hrdata[d];
      last_done  = cyc;
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      pend[d]    = 1'b0;
      low_cnt[d] = 0;
      low_err[d] = 1'b0;
    end
    forever begin
      @(negedge hclk);
      for (int d = 0; d < 2; d++) begin
        if (hreset) begin
          pend[d] = 1'b0;
        end else begin
          if (pend[d]) begin
            if (!hready[d]) begin
              low_cnt[d]++;
              if (hresp[d] == 2'd1) low_err[d] = 1'b1;
            end else begin
              complete(d);
              pend[d] = 1'b0;
            end
          end
          if (hsel[d] && hready[d] && htrans[d][1]) begin
            pend[d]    = 1'b1;
            low_cnt[d] = 0;
            low_err[d] = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  int t0;

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    acc_cyc    = 0;
    last_done  = 0;
    last_rdata = '0;
    hreset     = 1'b1;
    for (int d = 0; d < 2; d++) begin
      hsel[d]    = 1'b0;
      haddr[d]   = '0;
      htrans[d]  = 2'd0;
      hwrite[d]  = 1'b0;
      hsize[d]   = 3'd0;
      hburst[d]  = 3'd0;
      hwdata[d]  = '0;
      hbusreq[d] = 1'b0;
      hlock[d]   = 1'b0;
    end
    do_reset();

    // Reset state, then selected IDLE cycles
    for (int d = 0; d < 2; d++) begin
      hsel[d]   = 1'b1;
      htrans[d] = 2'd0;
    end
    repeat (5) begin
      @(negedge hclk);
      for (int d = 0; d < 2; d++) begin
        check("idle_hready", d, 64'(hready[d]), 64'd1);
        check("idle_hresp", d, 64'(hresp[d]), 64'd0);
        check("idle_hrdata", d, hrdata[d], 64'd0);
        check("rst_hgrant", d, 64'(hgrant[d]), 64'd0);
        check("rst_hmaster", d, 64'(hmaster[d]), 64'd0);
      end
      @(posedge hclk); #1;
    end
    hsel[1] = 1'b0;

    // Grant: registered one cycle, hmaster follows on the next cycle and holds
    hbusreq[0] = 1'b1;
    @(posedge hclk); #1;
    check("grant_set", 0, 64'(hgrant[0]), 64'd1);
    check("master_before", 0, 64'(hmaster[0]), 64'd0);
    @(posedge hclk); #1;
    check("master_set", 0, 64'(hmaster[0]), 64'd5);
    hbusreq[0] = 1'b0;
    @(posedge hclk); #1;
    check("grant_clear", 0, 64'(hgrant[0]), 64'd0);
    check("master_hold", 0, 64'(hmaster[0]), 64'd5);

    // Zero-wait write then read back
    issue(0, 32'h10, 1'b1, 3'd3, 64'h1122334455667788, 2'd2, 3'd0);
    issue(0, 32'h10, 1'b0, 3'd3, 64'd0, 2'd2, 3'd0);
    drain(0);
    check("word_readback", 0, last_rdata, 64'h1122334455667788);

    // Byte write into a zero word
    issue(0, 32'h1B, 1'b1, 3'd0, {8{8'hAA}}, 2'd2, 3'd0);
    issue(0, 32'h18, 1'b0, 3'd3, 64'd0, 2'd2, 3'd0);
    drain(0);
    check("byte_lane_word", 0, last_rdata, 64'h00000000AA000000);

    // Errors: out of range, misaligned, oversize, errored write, then a good read
    issue(0, 32'(MD*8), 1'b0, 3'd3, 64'd0, 2'd2, 3'd0);
    issue(0, 32'h2, 1'b0, 3'd2, 64'd0, 2'd2, 3'd0);
    issue(0, 32'h4, 1'b1, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 2'd2, 3'd0);
    issue(0, 32'h0, 1'b0, 3'd4, 64'd0, 2'd2, 3'd0);
    issue(0, 32'h0, 1'b0, 3'd3, 64'd0, 2'd2, 3'd0);
    issue(0, 32'(MD*8 - 8), 1'b1, 3'd3, 64'hCAFE_F00D_0123_4567, 2'd2, 3'd0);
    issue(0, 32'(MD*8 - 8), 1'b0, 3'd3, 64'd0, 2'd2, 3'd0);
    drain(0);
    check("top_word_readback", 0, last_rdata, 64'hCAFE_F00D_0123_4567);

    repeat (60) rand_xfer(0);
    drain(0);
    hsel[0] = 1'b0;

    // Three-wait instance: INCR4 read from zeroed memory
    issue(1, 32'h0, 1'b0, 3'd3, 64'd0, 2'd2, 3'd3);
    t0 = acc_cyc;
    issue(1, 32'h8, 1'b0, 3'd3, 64'd0, 2'd3, 3'd3);
    issue(1, 32'h10, 1'b0, 3'd3, 64'd0, 2'd3, 3'd3);
    issue(1, 32'h18, 1'b0, 3'd3, 64'd0, 2'd3, 3'd3);
    drain(1);
    check("incr4_cycles", 1, 64'(last_done - t0 + 1), 64'd16);

    repeat (25) rand_xfer(1);
    drain(1);

    // Reset during the wait phase of a write
    hsel[1]   = 1'b1;
    haddr[1]  = 32'h40;
    hwrite[1] = 1'b1;
    hsize[1]  = 3'd3;
    htrans[1] = 2'd2;
    wait_ready(1);
    @(posedge hclk); #1;
    htrans[1] = 2'd0;
    hwdata[1] = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge hclk);
    check("abort_in_wait", 1, 64'(hready[1]), 64'd0);
    @(posedge hclk); #1;
    hreset = 1'b1;
    @(posedge hclk); #1;
    hreset = 1'b0;
    clear_model();
    exp_q.delete();
    check("abort_hready", 1, 64'(hready[1]), 64'd1);
    check("abort_hresp", 1, 64'(hresp[1]), 64'd0);
    check("abort_hrdata", 1, hrdata[1], 64'd0);
    issue(1, 32'h40, 1'b0, 3'd3, 64'd0, 2'd2, 3'd0);
    drain(1);
    check("abort_no_write", 1, last_rdata, 64'd0);

    check("queue_empty", 1, 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
